// File: rtl/cpu_mode_ctrl_if.sv
// Memory-port bundle between the mode controller (master) and the program RAM (slave).
interface cpu_mode_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_mode_ctrl.sv
// Mode sequencer for the tiny CPU: selects IDLE/IN/CHECK/RUN, muxes the single
// memory port between loader, checker and datapath, and counts RUN cycles.
module cpu_mode_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_sel,
    input  logic          mode_go,
    input  logic [DW-1:0] load_data,
    input  logic          load_strobe,
    input  logic          check_next,
    input  logic          cpu_halt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_read,
    input  logic          cpu_write,
    cpu_mode_ctrl_if.master mem,
    output logic [1:0]    cpustate,
    output logic [AW-1:0] ld_addr,
    output logic [AW-1:0] chk_addr,
    output logic [DW-1:0] chk_data,
    output logic [CW-1:0] run_cycles
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_IN    = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    logic [1:0]    state_reg, state_next;
    logic [2:0]    hist_reg;
    logic [2:0]    level;
    logic [2:0]    edge_det;
    logic          go_edge, strobe_edge, next_edge;
    logic          wr_pulse_reg;
    logic [DW-1:0] wdata_reg;
    logic [AW-1:0] ld_addr_reg, chk_addr_reg;
    logic [DW-1:0] chk_data_reg;
    logic [CW-1:0] run_cycles_reg;
    logic          enter_in, enter_check, enter_run;

    // Rising-edge detectors: a held level yields a single event.
    assign level       = {check_next, load_strobe, mode_go};
    assign edge_det    = level & ~hist_reg;
    assign go_edge     = edge_det[0];
    assign strobe_edge = edge_det[1];
    assign next_edge   = edge_det[2];

    assign enter_in    = go_edge && (mode_sel == ST_IN);
    assign enter_check = go_edge && (mode_sel == ST_CHECK);
    assign enter_run   = go_edge && (mode_sel == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A mode_go edge outranks a halt arriving in the same cycle.
    always_comb begin
        state_next = state_reg;
        if (go_edge) begin
            state_next = mode_sel;
        end else if ((state_reg == ST_RUN) && cpu_halt) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg       <= '0;
            wr_pulse_reg   <= 1'b0;
            wdata_reg      <= '0;
            ld_addr_reg    <= '0;
            chk_addr_reg   <= '0;
            chk_data_reg   <= '0;
            run_cycles_reg <= '0;
        end else begin
            hist_reg <= level;

            // Only issue a write if we are still in IN when it would happen.
            wr_pulse_reg <= strobe_edge && (state_reg == ST_IN) && (state_next == ST_IN);
            if (strobe_edge && (state_reg == ST_IN)) begin
                wdata_reg <= load_data;
            end

            if (enter_in) begin
                ld_addr_reg <= '0;
            end else if (wr_pulse_reg && !go_edge) begin
                ld_addr_reg <= ld_addr_reg + 1'b1;
            end

            if (enter_check) begin
                chk_addr_reg <= '0;
            end else if ((state_reg == ST_CHECK) && next_edge) begin
                chk_addr_reg <= chk_addr_reg + 1'b1;
            end

            if (state_reg == ST_CHECK) begin
                chk_data_reg <= mem.mem_rdata;
            end

            if (enter_run) begin
                run_cycles_reg <= '0;
            end else if ((state_reg == ST_RUN) && (state_next == ST_RUN) &&
                         (run_cycles_reg != {CW{1'b1}})) begin
                run_cycles_reg <= run_cycles_reg + 1'b1;
            end
        end
    end

    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;
        case (state_reg)
            ST_IN: begin
                mem.mem_addr  = ld_addr_reg;
                mem.mem_wdata = wdata_reg;
                mem.mem_we    = wr_pulse_reg;
            end
            ST_CHECK: begin
                mem.mem_addr = chk_addr_reg;
                mem.mem_re   = 1'b1;
            end
            ST_RUN: begin
                mem.mem_addr  = cpu_addr;
                mem.mem_wdata = cpu_wdata;
                mem.mem_we    = cpu_write;
                mem.mem_re    = cpu_read;
            end
            default: begin
                mem.mem_addr = '0;
            end
        endcase
    end

    assign cpustate   = state_reg;
    assign ld_addr    = ld_addr_reg;
    assign chk_addr   = chk_addr_reg;
    assign chk_data   = chk_data_reg;
    assign run_cycles = run_cycles_reg;
endmodule
